bg_pixel_fetcher: RTL and testbench

//  Background tile fetcher. It is the producer/sequencer for the 8-deep PPU pixel FIFO.
//  Per tile it reads the map entry, the low bitplane and the high bitplane from VRAM,

---
 rtl/bg_pixel_fetcher.sv | 155 +++++++++++++++
 tb/tb_bg_pixel_fetcher.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/bg_pixel_fetcher.sv
// Background tile fetcher: reads map entry and both bitplanes for one tile,
// then streams its 8 pixels into the PPU pixel FIFO under back-pressure.
module bg_pixel_fetcher #(
   parameter logic [12:0] MAP0_BASE = 13'h1800,
   parameter logic [12:0] MAP1_BASE = 13'h1C00
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        stop,
   input  logic [7:0]  ly,
   input  logic [7:0]  scx,
   input  logic [7:0]  scy,
   input  logic        lcdc_bg_map,
   input  logic        lcdc_tile_data,
   output logic        vram_rd,
   output logic [12:0] vram_addr,
   input  logic [7:0]  vram_data,
   output logic        fifo_write_en,
   output logic [1:0]  fifo_color,
   input  logic        fifo_full,
   input  logic [3:0]  fifo_count,
   output logic        busy,
   output logic [4:0]  tile_x
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_TILE0,
      S_TILE1,
      S_LOW0,
      S_LOW1,
      S_HIGH0,
      S_HIGH1,
      S_PUSH
   } state_t;

   state_t      r_state;
   logic [4:0]  r_tile_x;
   logic [2:0]  r_pix_idx;
   logic [7:0]  r_tile_id;
   logic [7:0]  r_lo;
   logic [7:0]  r_hi;

   logic [7:0]  w_yy;
   logic [2:0]  w_row;
   logic [4:0]  w_col;
   logic [12:0] w_map_base;
   logic [12:0] w_map_addr;
   logic [12:0] w_row_off;
   logic [12:0] w_data_addr;
   logic [2:0]  w_bit_sel;
   logic        w_push_gate;

   // Scroll is sampled live, so every fetch step sees the current scx/scy.
   assign w_yy       = ly + scy;
   assign w_row      = w_yy[2:0];
   assign w_col      = scx[7:3] + r_tile_x;
   assign w_map_base = lcdc_bg_map ? MAP1_BASE : MAP0_BASE;
   assign w_map_addr = w_map_base + {3'b000, w_yy[7:3], w_col};
   assign w_row_off  = {9'd0, w_row, 1'b0};

   // Signed tile ids index around 0x1000; the 13-bit sum wraps naturally.
   always_comb begin
      if (lcdc_tile_data)
         w_data_addr = {1'b0, r_tile_id, 4'b0000} + w_row_off;
      else
         w_data_addr = 13'h1000 + {r_tile_id[7], r_tile_id, 4'b0000} + w_row_off;
   end

   // First pixel of a tile waits for an empty FIFO; the rest only for space.
   assign w_push_gate = (r_state == S_PUSH) &&
                        ((r_pix_idx == 3'd0) ? (fifo_count == 4'd0) : !fifo_full);
   assign w_bit_sel   = 3'd7 - r_pix_idx;

   assign fifo_write_en = w_push_gate;
   assign fifo_color    = w_push_gate ? {r_hi[w_bit_sel], r_lo[w_bit_sel]} : 2'b00;
   assign busy          = (r_state != S_IDLE);
   assign tile_x        = r_tile_x;

   always_comb begin
      vram_rd   = 1'b0;
      vram_addr = 13'd0;
      case (r_state)
         S_TILE0: begin
            vram_rd   = 1'b1;
            vram_addr = w_map_addr;
         end
         S_TILE1: vram_addr = w_map_addr;
         S_LOW0: begin
            vram_rd   = 1'b1;
            vram_addr = w_data_addr;
         end
         S_LOW1:  vram_addr = w_data_addr;
         S_HIGH0: begin
            vram_rd   = 1'b1;
            vram_addr = w_data_addr + 13'd1;
         end
         S_HIGH1: vram_addr = w_data_addr + 13'd1;
         default: begin
            vram_rd   = 1'b0;
            vram_addr = 13'd0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_tile_x  <= 5'd0;
         r_pix_idx <= 3'd0;
         r_tile_id <= 8'd0;
         r_lo      <= 8'd0;
         r_hi      <= 8'd0;
      end else if (stop) begin
         r_state   <= S_IDLE;
      end else if (start) begin
         r_state   <= S_TILE0;
         r_tile_x  <= 5'd0;
         r_pix_idx <= 3'd0;
      end else begin
         case (r_state)
            S_IDLE:  r_state <= S_IDLE;
            S_TILE0: r_state <= S_TILE1;
            S_TILE1: begin
               r_tile_id <= vram_data;
               r_state   <= S_LOW0;
            end
            S_LOW0:  r_state <= S_LOW1;
            S_LOW1: begin
               r_lo    <= vram_data;
               r_state <= S_HIGH0;
            end
            S_HIGH0: r_state <= S_HIGH1;
            S_HIGH1: begin
               r_hi    <= vram_data;
               r_state <= S_PUSH;
            end
            S_PUSH: begin
               if (w_push_gate) begin
                  if (r_pix_idx == 3'd7) begin
                     r_pix_idx <= 3'd0;
                     r_tile_x  <= r_tile_x + 5'd1;
                     r_state   <= S_TILE0;
                  end else begin
                     r_pix_idx <= r_pix_idx + 3'd1;
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bg_pixel_fetcher.sv
// Directed bench for bg_pixel_fetcher with a behavioural VRAM (1-cycle read latency).
module tb_bg_pixel_fetcher;

   logic        clk = 1'b0;
   logic        reset, start, stop;
   logic [7:0]  ly, scx, scy;
   logic        lcdc_bg_map, lcdc_tile_data;
   logic        vram_rd;
   logic [12:0] vram_addr;
   logic [7:0]  vram_data = 8'd0;
   logic        fifo_write_en;
   logic [1:0]  fifo_color;
   logic        fifo_full;
   logic [3:0]  fifo_count;
   logic        busy;
   logic [4:0]  tile_x;

   logic [7:0]  vram [0:8191];
   int          checks = 0;
   int          errors = 0;
   int          nwrites;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (vram_rd) vram_data <= vram[vram_addr];
   end

   bg_pixel_fetcher dut (
      .clk            (clk),
      .reset          (reset),
      .start          (start),
      .stop           (stop),
      .ly             (ly),
      .scx            (scx),
      .scy            (scy),
      .lcdc_bg_map    (lcdc_bg_map),
      .lcdc_tile_data (lcdc_tile_data),
      .vram_rd        (vram_rd),
      .vram_addr      (vram_addr),
      .vram_data      (vram_data),
      .fifo_write_en  (fifo_write_en),
      .fifo_color     (fifo_color),
      .fifo_full      (fifo_full),
      .fifo_count     (fifo_count),
      .busy           (busy),
      .tile_x         (tile_x)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
      $display("check %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_busy"}, {31'd0, busy}, 32'd0);
      check({tag, "_rd"}, {31'd0, vram_rd}, 32'd0);
      check({tag, "_addr"}, {19'd0, vram_addr}, 32'd0);
      check({tag, "_we"}, {31'd0, fifo_write_en}, 32'd0);
      check({tag, "_color"}, {30'd0, fifo_color}, 32'd0);
   endtask

   task automatic check_fetch(input string tag, input logic rd, input logic [12:0] addr);
      check({tag, "_rd"}, {31'd0, vram_rd}, {31'd0, rd});
      check({tag, "_addr"}, {19'd0, vram_addr}, {19'd0, addr});
   endtask

   task automatic check_push(input string tag, input logic we, input logic [1:0] color);
      check({tag, "_we"}, {31'd0, fifo_write_en}, {31'd0, we});
      check({tag, "_color"}, {30'd0, fifo_color}, {30'd0, color});
   endtask

   logic [1:0] exp2 [0:7];
   logic [1:0] exp4 [0:7];

   initial begin
      for (int i = 0; i < 8192; i++) vram[i] = 8'd0;
      vram[13'h1800] = 8'h01; vram[13'h0010] = 8'hF0; vram[13'h0011] = 8'hCC;
      vram[13'h1801] = 8'h02; vram[13'h0020] = 8'hAA; vram[13'h0021] = 8'h0F;
      vram[13'h1802] = 8'h03; vram[13'h0030] = 8'hFF; vram[13'h0031] = 8'hFF;
      vram[13'h080A] = 8'h55; vram[13'h080B] = 8'h33;
      exp2 = '{2'd3, 2'd3, 2'd1, 2'd1, 2'd2, 2'd2, 2'd0, 2'd0};
      exp4 = '{2'd1, 2'd0, 2'd1, 2'd0, 2'd3, 2'd2, 2'd3, 2'd2};

      reset = 1'b1; start = 1'b0; stop = 1'b0;
      ly = 8'd0; scx = 8'd0; scy = 8'd0;
      lcdc_bg_map = 1'b0; lcdc_tile_data = 1'b1;
      fifo_count = 4'd0; fifo_full = 1'b0;
      step(); step();
      reset = 1'b0; #1;
      check_idle("reset");
      check("reset_tile_x", {27'd0, tile_x}, 32'd0);

      // Basic tile: map 0, unsigned data
      start = 1'b1; step(); start = 1'b0; #1;
      check_fetch("t2_tile0", 1'b1, 13'h1800);
      check("t2_busy", {31'd0, busy}, 32'd1);
      step(); #1; check_fetch("t2_tile1", 1'b0, 13'h1800);
      step(); #1; check_fetch("t2_low0", 1'b1, 13'h0010);
      step(); step(); #1; check_fetch("t2_high0", 1'b1, 13'h0011);
      step(); step(); #1;
      for (int k = 0; k < 8; k++) begin
         check_push($sformatf("t2_pix%0d", k), 1'b1, exp2[k]);
         step(); #1;
      end
      check("t2_tile_x", {27'd0, tile_x}, 32'd1);
      check_fetch("t2_next_map", 1'b1, 13'h1801);

      // Back-pressure: count gate on first pixel, full gate afterwards
      fifo_count = 4'd3;
      for (int k = 0; k < 6; k++) step();
      #1; check_push("t4_wait_cnt_a", 1'b0, 2'd0);
      step(); #1; check_push("t4_wait_cnt_b", 1'b0, 2'd0);
      fifo_count = 4'd0; #1; check_push("t4_pix0", 1'b1, exp4[0]);
      step(); fifo_count = 4'd1; #1; check_push("t4_pix1", 1'b1, exp4[1]);
      step(); fifo_full = 1'b1; #1; check_push("t4_stall_a", 1'b0, 2'd0);
      step(); #1; check_push("t4_stall_b", 1'b0, 2'd0);
      fifo_full = 1'b0; #1; check_push("t4_resume_pix2", 1'b1, exp4[2]);
      step(); #1;
      for (int k = 3; k < 8; k++) begin
         check_push($sformatf("t4_pix%0d", k), 1'b1, exp4[k]);
         step(); #1;
      end
      fifo_count = 4'd0; #1;
      check("t4_tile_x", {27'd0, tile_x}, 32'd2);

      // Stop in PUSH after 3 writes
      for (int k = 0; k < 6; k++) step();
      #1;
      for (int k = 0; k < 3; k++) begin
         check_push($sformatf("t5_pix%0d", k), 1'b1, 2'd3);
         step(); #1;
      end
      stop = 1'b1; fifo_full = 1'b1;
      step(); stop = 1'b0; fifo_full = 1'b0; #1;
      check_idle("t5_stopped");
      nwrites = 0;
      for (int k = 0; k < 10; k++) begin
         step();
         if (fifo_write_en) nwrites++;
      end
      check("t5_no_writes", nwrites, 32'd0);
      start = 1'b1; step(); start = 1'b0; #1;
      check_fetch("t5_restart", 1'b1, 13'h1800);
      check("t5_restart_tile_x", {27'd0, tile_x}, 32'd0);

      // start together with stop: stop wins
      start = 1'b1; stop = 1'b1; step(); start = 1'b0; stop = 1'b0; #1;
      check("stop_wins_busy", {31'd0, busy}, 32'd0);

      // Signed tile data, row 5
      ly = 8'd3; scy = 8'd2; lcdc_tile_data = 1'b0; vram[13'h1800] = 8'h80;
      start = 1'b1; step(); start = 1'b0; #1;
      check_fetch("t3_tile0", 1'b1, 13'h1800);
      step(); step(); #1; check_fetch("t3_low0", 1'b1, 13'h080A);
      step(); step(); #1; check_fetch("t3_high0", 1'b1, 13'h080B);
      step(); step(); #1;
      check_push("t3_pix0", 1'b1, 2'd0); step(); #1;
      check_push("t3_pix1", 1'b1, 2'd1); step(); #1;
      check_push("t3_pix2", 1'b1, 2'd2); step(); #1;
      check_push("t3_pix3", 1'b1, 2'd3); step(); #1;

      // Reset while in PUSH with pix_idx=4
      reset = 1'b1; step(); reset = 1'b0; #1;
      check_idle("t1_reset_push");
      check("t1_tile_x", {27'd0, tile_x}, 32'd0);

      // Wrapping map address, map 1; includes a restart mid-fetch
      ly = 8'd1; scx = 8'hF8; scy = 8'hFF; lcdc_bg_map = 1'b1; lcdc_tile_data = 1'b1;
      start = 1'b1; step(); start = 1'b0; #1;
      check_fetch("t6_col31", 1'b1, 13'h1C1F);
      step(); step();
      start = 1'b1; step(); start = 1'b0; #1;
      check_fetch("t6_restart_busy", 1'b1, 13'h1C1F);
      check("t6_restart_tile_x", {27'd0, tile_x}, 32'd0);
      for (int k = 0; k < 6; k++) step();
      nwrites = 0;
      for (int k = 0; k < 8; k++) begin
         #1;
         if (fifo_write_en) nwrites++;
         step();
      end
      #1;
      check("t6_writes", nwrites, 32'd8);
      check("t6_tile_x", {27'd0, tile_x}, 32'd1);
      check_fetch("t6_wrap", 1'b1, 13'h1C00);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
